// File: rtl/multi_channel_data_sync_pkg.sv
// Shared definitions for the multi-channel CDC data synchroniser:
// event-mode encodings, the minimum qualifier sync depth and the
// per-channel action decode used by every channel instance.
package cdc_pkg;

  // Event-mode encodings for the MODE parameter.
  localparam int MODE_LEVEL  = 0;  // event on rising edge of the synced qualifier
  localparam int MODE_TOGGLE = 1;  // event on either edge of the synced qualifier

  // Fewest flops allowed on a qualifier synchroniser chain.
  localparam int CDC_MIN_STAGES = 2;

  // What a channel does at the next clock edge.
  typedef enum logic [1:0] {
    ACT_IDLE    = 2'd0,  // nothing happens
    ACT_CAPTURE = 2'd1,  // load new data, (re)assert valid, pulse
    ACT_DROP    = 2'd2,  // event lost because held data is unconsumed
    ACT_CONSUME = 2'd3   // consumer took the held data, valid falls
  } chan_action_e;

  // Decide a channel's action from the detected event, the hold state
  // and the consumer's ready. A consumer accepting in the same cycle as
  // a new event frees the holding register, so the event is captured.
  function automatic chan_action_e chan_action(input logic evt,
                                               input logic valid,
                                               input logic ready);
    chan_action_e act;
    act = ACT_IDLE;
    if (evt) begin
      act = (!valid || ready) ? ACT_CAPTURE : ACT_DROP;
    end else if (valid && ready) begin
      act = ACT_CONSUME;
    end
    return act;
  endfunction

endpackage

// File: rtl/multi_channel_data_sync_if.sv
// Bundle of the per-channel qualifier, data and handshake signals that
// cross into the destination domain. The producer/consumer side uses
// the master modport; the synchroniser uses the slave modport.
interface multi_channel_data_sync_if #(
  parameter int NUM_CH    = 2,
  parameter int BUS_WIDTH = 8
);

  logic [NUM_CH-1:0]           bus_enable;    // async qualifier per channel
  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus;    // async data, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
  logic [NUM_CH-1:0]           data_ready;    // consumer accepts held data
  logic [NUM_CH-1:0]           overrun_clr;   // clears sticky overrun
  logic [NUM_CH*BUS_WIDTH-1:0] sync_bus;      // captured data, same packing
  logic [NUM_CH-1:0]           enable_pulse;  // one cycle per accepted capture
  logic [NUM_CH-1:0]           data_valid;    // held data not yet consumed
  logic [NUM_CH-1:0]           overrun;       // sticky: an event was dropped

  modport master (
    output bus_enable, unsync_bus, data_ready, overrun_clr,
    input  sync_bus, enable_pulse, data_valid, overrun
  );

  modport slave (
    input  bus_enable, unsync_bus, data_ready, overrun_clr,
    output sync_bus, enable_pulse, data_valid, overrun
  );

endinterface

// File: rtl/multi_channel_data_sync_sync_channel.sv
// One synchroniser channel: qualifier flop chain, edge detection against
// a reference flop, a capture register with valid/ready hold handshake
// and a sticky overrun flag. Every output comes straight from a flop.
module sync_channel
  import cdc_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int MODE       = MODE_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 bus_enable_i,
  input  logic [BUS_WIDTH-1:0] unsync_bus_i,
  input  logic                 data_ready_i,
  input  logic                 overrun_clr_i,
  output logic [BUS_WIDTH-1:0] sync_bus_o,
  output logic                 enable_pulse_o,
  output logic                 data_valid_o,
  output logic                 overrun_o
);

  logic [NUM_STAGES-1:0] sync_q;
  logic                  edge_ref_q;
  logic                  evt_w;
  chan_action_e          action_w;

  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  pulse_q, pulse_d;
  logic                  ovr_q, ovr_d;

  // Qualifier synchroniser chain plus the reference copy of its last stage.
  // NOTE: sequential state uses non-blocking assignments so every flop in
  // the chain samples the value its predecessor held before this edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q     <= '0;
      edge_ref_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[NUM_STAGES-2:0], bus_enable_i};
      edge_ref_q <= sync_q[NUM_STAGES-1];
    end
  end

  // Event = change of the synced qualifier against its previous value.
  // The reference resets to 0, so a qualifier already high at reset
  // release yields exactly one event in either mode.
  generate
    if (MODE == MODE_TOGGLE) begin : g_toggle
      assign evt_w = sync_q[NUM_STAGES-1] ^ edge_ref_q;
    end else begin : g_level
      assign evt_w = sync_q[NUM_STAGES-1] & ~edge_ref_q;
    end
  endgenerate

  assign action_w = chan_action(evt_w, valid_q, data_ready_i);

  // Next-state decode for the hold register, valid, pulse and overrun.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pulse_d = 1'b0;
    ovr_d   = overrun_clr_i ? 1'b0 : ovr_q;
    case (action_w)
      ACT_CAPTURE: begin
        data_d  = unsync_bus_i;
        valid_d = 1'b1;
        pulse_d = 1'b1;
      end
      // Oldest data is kept; a drop overrides a concurrent clear.
      ACT_DROP:    ovr_d   = 1'b1;
      ACT_CONSUME: valid_d = 1'b0;
      default:     ;
    endcase
  end

  // Capture register and handshake flags.
  // NOTE: the data register is reset as well, because a reset in the middle
  // of operation must discard held data and present zero on sync_bus.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sync_bus_o     = data_q;
  assign enable_pulse_o = pulse_q;
  assign data_valid_o   = valid_q;
  assign overrun_o      = ovr_q;

endmodule

// File: rtl/multi_channel_data_sync.sv
// Destination-domain synchroniser for NUM_CH independent buses. Each
// channel is a self-contained sync_channel; the top only slices the
// packed buses. The interface instance must be built with the same
// NUM_CH and BUS_WIDTH as this module.
module multi_channel_data_sync
  import cdc_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_CH     = 2,
  parameter int MODE       = MODE_LEVEL
) (
  input  logic                      CLK,
  input  logic                      RST,
  multi_channel_data_sync_if.slave  sync_if
);

  // Reject configurations the channel logic cannot implement.
  generate
    if (NUM_STAGES < CDC_MIN_STAGES) begin : g_bad_stages
      $error("multi_channel_data_sync: NUM_STAGES must be >= 2");
    end
    if (NUM_CH < 1) begin : g_bad_ch
      $error("multi_channel_data_sync: NUM_CH must be >= 1");
    end
    if (MODE != MODE_LEVEL && MODE != MODE_TOGGLE) begin : g_bad_mode
      $error("multi_channel_data_sync: MODE must be 0 (LEVEL) or 1 (TOGGLE)");
    end
  endgenerate

  // One independent channel per bus; no cross-channel coupling.
  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      sync_channel #(
        .NUM_STAGES (NUM_STAGES),
        .BUS_WIDTH  (BUS_WIDTH),
        .MODE       (MODE)
      ) u_ch (
        .CLK            (CLK),
        .RST            (RST),
        .bus_enable_i   (sync_if.bus_enable[c]),
        .unsync_bus_i   (sync_if.unsync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
        .data_ready_i   (sync_if.data_ready[c]),
        .overrun_clr_i  (sync_if.overrun_clr[c]),
        .sync_bus_o     (sync_if.sync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
        .enable_pulse_o (sync_if.enable_pulse[c]),
        .data_valid_o   (sync_if.data_valid[c]),
        .overrun_o      (sync_if.overrun[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_channel_data_sync.sv
// Bench for multi_channel_data_sync. Three instances share one stimulus:
// LEVEL with 2 stages, TOGGLE with 2 stages, LEVEL with 3 stages. A
// behavioural model predicts every output from the qualifier history
// sampled at each edge; directed literal checks pin key moments.
module tb_multi_channel_data_sync;
  import cdc_pkg::*;

  localparam int NCH = 2;
  localparam int BW  = 8;
  localparam int NI  = 3;

  function automatic int stages_of(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic int mode_of(input int i);
    return (i == 1) ? MODE_TOGGLE : MODE_LEVEL;
  endfunction

  logic CLK = 1'b0;
  logic RST = 1'b0;

  initial forever #5 CLK = ~CLK;

  // Shared stimulus
  logic [NCH-1:0]    en, rdy, clr;
  logic [NCH*BW-1:0] bus;

  multi_channel_data_sync_if #(.NUM_CH(NCH), .BUS_WIDTH(BW)) if0 ();
  multi_channel_data_sync_if #(.NUM_CH(NCH), .BUS_WIDTH(BW)) if1 ();
  multi_channel_data_sync_if #(.NUM_CH(NCH), .BUS_WIDTH(BW)) if2 ();

  assign if0.bus_enable = en;  assign if0.unsync_bus = bus;
  assign if0.data_ready = rdy; assign if0.overrun_clr = clr;
  assign if1.bus_enable = en;  assign if1.unsync_bus = bus;
  assign if1.data_ready = rdy; assign if1.overrun_clr = clr;
  assign if2.bus_enable = en;  assign if2.unsync_bus = bus;
  assign if2.data_ready = rdy; assign if2.overrun_clr = clr;

  logic [NCH*BW-1:0] o_bus   [NI];
  logic [NCH-1:0]    o_pulse [NI];
  logic [NCH-1:0]    o_valid [NI];
  logic [NCH-1:0]    o_ovr   [NI];

  assign o_bus[0] = if0.sync_bus; assign o_pulse[0] = if0.enable_pulse;
  assign o_valid[0] = if0.data_valid; assign o_ovr[0] = if0.overrun;
  assign o_bus[1] = if1.sync_bus; assign o_pulse[1] = if1.enable_pulse;
  assign o_valid[1] = if1.data_valid; assign o_ovr[1] = if1.overrun;
  assign o_bus[2] = if2.sync_bus; assign o_pulse[2] = if2.enable_pulse;
  assign o_valid[2] = if2.data_valid; assign o_ovr[2] = if2.overrun;

  multi_channel_data_sync #(.NUM_STAGES(2), .BUS_WIDTH(BW), .NUM_CH(NCH), .MODE(MODE_LEVEL))
    u_lvl2 (.CLK(CLK), .RST(RST), .sync_if(if0.slave));
  multi_channel_data_sync #(.NUM_STAGES(2), .BUS_WIDTH(BW), .NUM_CH(NCH), .MODE(MODE_TOGGLE))
    u_tgl2 (.CLK(CLK), .RST(RST), .sync_if(if1.slave));
  multi_channel_data_sync #(.NUM_STAGES(3), .BUS_WIDTH(BW), .NUM_CH(NCH), .MODE(MODE_LEVEL))
    u_lvl3 (.CLK(CLK), .RST(RST), .sync_if(if2.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[k] = qualifier sampled k edges ago (0 before reset release).
  // An edge captures when the qualifier sampled N edges earlier differs
  // from (TOGGLE) or rose against (LEVEL) the sample one edge before it.
  logic [7:0]    m_hist  [NI][NCH];
  logic [BW-1:0] m_data  [NI][NCH];
  logic          m_valid [NI][NCH];
  logic          m_pulse [NI][NCH];
  logic          m_ovr   [NI][NCH];
  logic          m_cur, m_prv, m_ev, m_v0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < NCH; c++) begin
          m_hist[i][c] = '0; m_data[i][c] = '0; m_valid[i][c] = 1'b0;
          m_pulse[i][c] = 1'b0; m_ovr[i][c] = 1'b0;
        end
    end else begin
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < NCH; c++) begin
          m_hist[i][c] = {m_hist[i][c][6:0], en[c]};
          m_cur = m_hist[i][c][stages_of(i)];
          m_prv = m_hist[i][c][stages_of(i)+1];
          m_ev  = (mode_of(i) == MODE_TOGGLE) ? (m_cur != m_prv) : (m_cur && !m_prv);
          m_v0  = m_valid[i][c];
          m_pulse[i][c] = 1'b0;
          if (m_ev && (!m_v0 || rdy[c])) begin
            m_data[i][c]  = bus[c*BW +: BW];
            m_valid[i][c] = 1'b1;
            m_pulse[i][c] = 1'b1;
          end else if (!m_ev && m_v0 && rdy[c]) begin
            m_valid[i][c] = 1'b0;
          end
          if (m_ev && m_v0 && !rdy[c]) m_ovr[i][c] = 1'b1;
          else if (clr[c])             m_ovr[i][c] = 1'b0;
        end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NCH*BW-1:0] e_bus;
  logic [NCH-1:0]    e_pulse, e_valid, e_ovr;

  initial forever begin
    @(posedge CLK);
    #2;
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NCH; c++) begin
        e_bus[c*BW +: BW] = m_data[i][c];
        e_pulse[c] = m_pulse[i][c];
        e_valid[c] = m_valid[i][c];
        e_ovr[c]   = m_ovr[i][c];
      end
      check($sformatf("model_bus[%0d]", i),   32'(o_bus[i]),   32'(e_bus));
      check($sformatf("model_pulse[%0d]", i), 32'(o_pulse[i]), 32'(e_pulse));
      check($sformatf("model_valid[%0d]", i), 32'(o_valid[i]), 32'(e_valid));
      check($sformatf("model_ovr[%0d]", i),   32'(o_ovr[i]),   32'(e_ovr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    en = '0; bus = '0; rdy = '0; clr = '0; RST = 1'b0;
    tick(3);
    check("reset_bus",   32'(o_bus[0]),   32'h0);
    check("reset_pulse", 32'(o_pulse[0]), 32'h0);
    check("reset_valid", 32'(o_valid[0]), 32'h0);
    check("reset_ovr",   32'(o_ovr[0]),   32'h0);
    RST = 1'b1;

    // T1: capture on third edge, one-cycle pulse
    en[0] = 1'b1; bus[7:0] = 8'hA5;
    tick(2);
    check("t1_no_early_pulse", 32'(o_pulse[0][0]), 32'h0);
    tick(1);
    check("t1_bus",   32'(o_bus[0][7:0]),  32'hA5);
    check("t1_pulse", 32'(o_pulse[0][0]),  32'h1);
    check("t1_valid", 32'(o_valid[0][0]),  32'h1);
    tick(1);
    check("t1_pulse_once", 32'(o_pulse[0][0]), 32'h0);

    // T2: hold until ready
    tick(10);
    check("t2_hold_valid", 32'(o_valid[0][0]), 32'h1);
    rdy = 2'b01; tick(1); rdy = '0;
    check("t2_consumed", 32'(o_valid[0][0]), 32'h0);
    check("t2_bus_kept", 32'(o_bus[0][7:0]), 32'hA5);

    // T3: overrun keeps oldest data, sticky, clear, set-wins
    en[0] = 1'b0; tick(4); en[0] = 1'b1; tick(4);
    check("t3_rearm_valid", 32'(o_valid[0][0]), 32'h1);
    en[0] = 1'b0; tick(4); en[0] = 1'b1; bus[7:0] = 8'h3C; tick(4);
    check("t3_keep_old", 32'(o_bus[0][7:0]), 32'hA5);
    check("t3_ovr_set",  32'(o_ovr[0][0]),   32'h1);
    tick(3);
    check("t3_ovr_sticky", 32'(o_ovr[0][0]), 32'h1);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    check("t3_ovr_clr", 32'(o_ovr[0][0]), 32'h0);
    en[0] = 1'b0; tick(4); en[0] = 1'b1; bus[7:0] = 8'h77; clr[0] = 1'b1;
    tick(3);
    clr[0] = 1'b0;
    check("t3_set_wins", 32'(o_ovr[0][0]), 32'h1);
    check("t3_set_keep", 32'(o_bus[0][7:0]), 32'hA5);
    clr = 2'b11; rdy = 2'b11; tick(6); clr = '0;
    check("t3_clean_valid", 32'(o_valid[0][0]), 32'h0);
    check("t3_clean_ovr",   32'(o_ovr[0][0]),   32'h0);

    // T4: toggle mode, four toggles with ready held high
    for (int k = 1; k <= 4; k++) begin
      bus[7:0] = 8'(k); en[0] = ~en[0];
      tick(3);
      check($sformatf("t4_pulse_%0d", k), 32'(o_pulse[1][0]), 32'h1);
      check($sformatf("t4_bus_%0d", k),   32'(o_bus[1][7:0]), 32'(k));
      tick(2);
    end
    check("t4_no_ovr", 32'(o_ovr[1][0]), 32'h0);

    // T5: event coincident with ready while valid; then dual-channel fire
    rdy = '0; en[0] = 1'b0; tick(4); en[0] = 1'b1; bus[7:0] = 8'h11; tick(4);
    en[0] = 1'b0; tick(4); en[0] = 1'b1; bus[7:0] = 8'h22; tick(2);
    rdy[0] = 1'b1; tick(1); rdy[0] = 1'b0;
    check("t5_new_bus", 32'(o_bus[0][7:0]), 32'h22);
    check("t5_valid",   32'(o_valid[0][0]), 32'h1);
    check("t5_pulse",   32'(o_pulse[0][0]), 32'h1);
    check("t5_no_ovr",  32'(o_ovr[0][0]),   32'h0);
    rdy = 2'b11; en = 2'b00; tick(4);
    en = 2'b11; bus = 16'hC35A; tick(3);
    check("t5_dual_bus",   32'(o_bus[0]),   32'hC35A);
    check("t5_dual_pulse", 32'(o_pulse[0]), 32'h3);

    // T6: reset mid-operation, then release with qualifier held high
    rdy = '0; en = '0; tick(4);
    en = 2'b11; bus = 16'h4433; tick(4);
    en = '0; tick(4);
    en = 2'b11; bus = 16'h9966; tick(1);
    RST = 1'b0; #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("t6_rst_bus[%0d]", i),   32'(o_bus[i]),   32'h0);
      check($sformatf("t6_rst_pulse[%0d]", i), 32'(o_pulse[i]), 32'h0);
      check($sformatf("t6_rst_valid[%0d]", i), 32'(o_valid[i]), 32'h0);
      check($sformatf("t6_rst_ovr[%0d]", i),   32'(o_ovr[i]),   32'h0);
    end
    tick(2);
    RST = 1'b1;
    tick(2);
    check("t6_lvl2_early", 32'(o_pulse[0]), 32'h0);
    tick(1);
    check("t6_lvl2_pulse", 32'(o_pulse[0]), 32'h3);
    check("t6_lvl2_bus",   32'(o_bus[0]),   32'h9966);
    check("t6_tgl2_pulse", 32'(o_pulse[1]), 32'h3);
    check("t6_lvl3_early", 32'(o_pulse[2]), 32'h0);
    tick(1);
    check("t6_lvl2_once",  32'(o_pulse[0]), 32'h0);
    check("t6_lvl3_pulse", 32'(o_pulse[2]), 32'h3);
    check("t6_lvl3_bus",   32'(o_bus[2]),   32'h9966);
    tick(1);
    check("t6_lvl3_once",  32'(o_pulse[2]), 32'h0);
    check("t6_no_ovr",     32'(o_ovr[2]),   32'h0);

    // Randomised traffic, with one reset in the middle
    for (int n = 0; n < 600; n++) begin
      @(negedge CLK);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 4) == 0) begin
          en[c] = ~en[c];
          bus[c*BW +: BW] = 8'($urandom);
        end
        rdy[c] = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        clr[c] = ($urandom_range(0, 15) == 0);
      end
      if (n == 350) RST = 1'b0;
      if (n == 353) RST = 1'b1;
    end
    rdy = '0; clr = '0;
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
